// File: rtl/ring_ctrl_pkg.sv
// Shared types and sizing helpers for the ring buffer burst controller.
package ring_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int AR_LEN_W = 8;

  // Width able to hold 0..depth inclusive (level and inflight counters).
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_burst_ctrl_if.sv
// Job, DMA read-address/read-data and ring buffer signals of ring_burst_ctrl.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface ring_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int BUF_DEPTH  = 256
);
  localparam int LVL_W = ring_ctrl_pkg::lvl_width(BUF_DEPTH);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_bursts;
  logic                  busy;
  logic                  done;
  logic                  err_last;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_ready;
  logic                  buf_wen;
  logic                  buf_ren;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      level;

  modport master (
    input  start, base_addr, num_bursts, ar_ready, r_valid, r_last, out_ready,
    output busy, done, err_last, ar_valid, ar_addr, ar_len, r_ready,
           buf_wen, buf_ren, out_valid, level
  );

  modport slave (
    output start, base_addr, num_bursts, ar_ready, r_valid, r_last, out_ready,
    input  busy, done, err_last, ar_valid, ar_addr, ar_len, r_ready,
           buf_wen, buf_ren, out_valid, level
  );
endinterface

// File: rtl/ring_burst_addr_gen.sv
// Burst address stepper: holds the current request address and counts issued bursts.
module ring_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] STRIDE = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [CNT_WIDTH-1:0]  num_i,
  input  logic                  fire_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  pending_o,
  output logic                  last_o
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;

  always_comb begin
    addr_d   = addr_q;
    num_d    = num_q;
    issued_d = issued_q;
    if (load_i) begin
      addr_d   = base_i;
      num_d    = num_i;
      issued_d = '0;
    end else if (fire_i) begin
      // Wraps naturally modulo 2^ADDR_WIDTH.
      addr_d   = addr_q + STRIDE;
      issued_d = issued_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
    end else begin
      addr_q   <= addr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
    end
  end

  assign addr_o    = addr_q;
  assign pending_o = issued_q < num_q;
  assign last_o    = issued_q == (num_q - CNT_WIDTH'(1));
endmodule

// File: rtl/ring_burst_ctrl.sv
// Burst read controller: reserves ring space before each DMA request and drains the ring.
module ring_burst_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LENGTH = 128,
  parameter int BUF_DEPTH    = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ring_burst_ctrl_if.master bus,
  output state_t            state_o
);
  localparam int LVL_W  = lvl_width(BUF_DEPTH);
  localparam int RES_W  = LVL_W + 2;
  localparam int BEAT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(BURST_LENGTH * DATA_WIDTH / 8);
  localparam logic [LVL_W-1:0]      BL_LVL    = LVL_W'(BURST_LENGTH);
  localparam logic [LVL_W-1:0]      ONE_LVL   = LVL_W'(1);
  localparam logic [RES_W-1:0]      BL_RES    = RES_W'(BURST_LENGTH);
  localparam logic [RES_W-1:0]      DEPTH_RES = RES_W'(BUF_DEPTH);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic              busy, start_acc, ar_valid, ar_fire, wen, ren, out_valid;
  logic              space_ok, issue_pending, last_burst;
  logic [RES_W-1:0]  reserved;

  ring_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .STRIDE     (STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (start_acc),
    .base_i    (bus.base_addr),
    .num_i     (bus.num_bursts),
    .fire_i    (ar_fire),
    .addr_o    (bus.ar_addr),
    .pending_o (issue_pending),
    .last_o    (last_burst)
  );

  assign busy      = state_q != ST_IDLE;
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  // Only a request raises reserved, so ar_valid cannot drop before ar_ready.
  assign reserved  = RES_W'(level_q) + RES_W'(inflight_q);
  assign space_ok  = (reserved + BL_RES) <= DEPTH_RES;
  assign ar_valid  = (state_q == ST_ISSUE) && issue_pending && space_ok;
  assign ar_fire   = ar_valid && bus.ar_ready;
  assign wen       = bus.r_valid && busy;
  assign out_valid = level_q != '0;
  assign ren       = out_valid && bus.out_ready;

  always_comb begin
    level_d    = level_q;
    inflight_d = inflight_q;
    beat_d     = beat_q;
    err_d      = err_q;
    if (wen && !ren) level_d = level_q + ONE_LVL;
    if (ren && !wen) level_d = level_q - ONE_LVL;
    if (ar_fire) inflight_d = inflight_d + BL_LVL;
    if (wen && inflight_q != '0) inflight_d = inflight_d - ONE_LVL;
    if (start_acc) begin
      beat_d = '0;
      err_d  = 1'b0;
    end else if (wen) begin
      if (inflight_q == '0) err_d = 1'b1;
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        if (!bus.r_last) err_d = 1'b1;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        if (bus.r_last) err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.num_bursts == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (ar_fire && last_burst) state_d = ST_DRAIN;
      // Looks at next-cycle counts so done follows the final read by one cycle.
      ST_DRAIN: if (inflight_d == '0 && level_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      inflight_q <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign state_o       = state_q;
  assign bus.busy      = busy;
  assign bus.done      = state_q == ST_DONE;
  assign bus.err_last  = err_q;
  assign bus.ar_valid  = ar_valid;
  assign bus.ar_len    = AR_LEN_W'(BURST_LENGTH - 1);
  assign bus.r_ready   = busy;
  assign bus.buf_wen   = wen;
  assign bus.buf_ren   = ren;
  assign bus.out_valid = out_valid;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_ring_burst_ctrl.sv
// Directed bench for ring_burst_ctrl with a DMA responder model and a scoreboard monitor.
module tb_ring_burst_ctrl;
  import ring_ctrl_pkg::*;

  localparam int BL    = 4;
  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ring_burst_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16), .BUF_DEPTH(DEPTH)) bus ();
  state_t state_o;

  ring_burst_ctrl #(
    .DATA_WIDTH   (32),
    .BURST_LENGTH (BL),
    .BUF_DEPTH    (DEPTH),
    .ADDR_WIDTH   (32),
    .CNT_WIDTH    (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ar_q[$];
  logic        exp_done_q[$];
  int          ar_fire_level[$];
  int cyc = 0, ar_cnt = 0, wen_cnt = 0, ren_cnt = 0, done_cnt = 0, arvalid_cyc = 0;
  int start_cyc = 0, last_ren_cyc = 0, level_max = 0;
  logic prev_both = 1'b0;
  logic [31:0] prev_level = '0;
  bit err_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"},     32'(state_o), 32'(ST_IDLE));
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_err"},       32'(bus.err_last), 0);
    check({tag, "_ar_valid"},  32'(bus.ar_valid), 0);
    check({tag, "_ar_addr"},   bus.ar_addr, 0);
    check({tag, "_r_ready"},   32'(bus.r_ready), 0);
    check({tag, "_buf_wen"},   32'(bus.buf_wen), 0);
    check({tag, "_buf_ren"},   32'(bus.buf_ren), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_level"},     32'(bus.level), 0);
  endtask

  // driver tasks
  task automatic start_job(input logic [31:0] base, input logic [15:0] num);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.num_bursts = num;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now({name, "_done_timeout"});
  endtask

  task automatic clear_stats();
    ar_cnt = 0; wen_cnt = 0; ren_cnt = 0; arvalid_cyc = 0; level_max = 0;
    ar_fire_level.delete();
  endtask

  // DMA responder: returns BL beats per accepted request, r_last per err_mode
  int pending = 0;
  int beat_idx = 0;
  bit r_acc = 1'b0;
  initial begin
    bus.r_valid = 1'b0;
    bus.r_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ar_valid && bus.ar_ready) pending += BL;
      r_acc = bus.r_valid && bus.r_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        pending  = 0;
        beat_idx = 0;
      end else if (r_acc) begin
        pending--;
        beat_idx = (beat_idx + 1) % BL;
      end
      bus.r_valid = pending > 0;
      bus.r_last  = (pending > 0) && (beat_idx == (err_mode ? 1 : BL - 1));
    end
  end

  // monitor: pops expectations when the DUT presents a request or a done pulse
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_both = 1'b0;
        continue;
      end
      if (prev_both) check("level_hold_on_wr_rd", 32'(bus.level), prev_level);
      prev_both  = bus.buf_wen && bus.buf_ren;
      prev_level = 32'(bus.level);
      if (int'(bus.level) > level_max) level_max = int'(bus.level);
      if (bus.start && state_o == ST_IDLE) start_cyc = cyc;
      if (bus.ar_valid) arvalid_cyc++;
      if (bus.ar_valid && bus.ar_ready) begin
        ar_cnt++;
        ar_fire_level.push_back(int'(bus.level));
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else check("ar_addr", bus.ar_addr, exp_ar_q.pop_front());
        check("ar_len", 32'(bus.ar_len), 3);
      end
      if (bus.buf_wen) wen_cnt++;
      if (bus.buf_ren) begin
        ren_cnt++;
        last_ren_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) fail_now("done_unexpected");
        else check("done_err_last", 32'(bus.err_last), 32'(exp_done_q.pop_front()));
        check("done_latency",
              32'(cyc - ((last_ren_cyc > start_cyc) ? last_ren_cyc : start_cyc)), 1);
      end
    end
  end

  // directed sequence
  initial begin
    bit seen;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.num_bursts = '0;
    bus.ar_ready   = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_ar_len", 32'(bus.ar_len), 3);
    rst_n = 1'b1;

    // single burst
    bus.ar_ready  = 1'b1;
    bus.out_ready = 1'b1;
    clear_stats();
    exp_ar_q.push_back(32'h0000_1000);
    exp_done_q.push_back(1'b0);
    start_job(32'h0000_1000, 16'd1);
    wait_done("single", 100);
    check("single_wen", 32'(wen_cnt), 4);
    check("single_ren", 32'(ren_cnt), 4);
    check("single_ar_cnt", 32'(ar_cnt), 1);
    @(negedge clk); #1;
    check("single_idle_after", 32'(state_o), 32'(ST_IDLE));

    // back-pressure: ring fills to 8, third request held until level drops to 4
    bus.out_ready = 1'b0;
    clear_stats();
    exp_ar_q.push_back(32'h0000_1000);
    exp_ar_q.push_back(32'h0000_1010);
    exp_ar_q.push_back(32'h0000_1020);
    exp_ar_q.push_back(32'h0000_1030);
    exp_done_q.push_back(1'b0);
    start_job(32'h0000_1000, 16'd4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.level == 4'd8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("bp_fill_timeout");
    repeat (4) @(negedge clk);
    #1;
    check("bp_ar_cnt_held", 32'(ar_cnt), 2);
    check("bp_ar_valid_held", 32'(bus.ar_valid), 0);
    check("bp_level_full", 32'(bus.level), 8);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("bp", 300);
    check("bp_third_ar_level", (ar_fire_level.size() > 2) ? 32'(ar_fire_level[2]) : 32'hFFFF_FFFF, 4);
    check("bp_level_max", 32'(level_max), 8);
    check("bp_wen_total", 32'(wen_cnt), 16);
    check("bp_ren_total", 32'(ren_cnt), 16);
    check("bp_ar_cnt", 32'(ar_cnt), 4);

    // address wrap
    clear_stats();
    exp_ar_q.push_back(32'hFFFF_FFF8);
    exp_ar_q.push_back(32'h0000_0008);
    exp_done_q.push_back(1'b0);
    start_job(32'hFFFF_FFF8, 16'd2);
    wait_done("wrap", 200);
    check("wrap_ar_cnt", 32'(ar_cnt), 2);

    // zero bursts
    clear_stats();
    exp_done_q.push_back(1'b0);
    start_job(32'h0000_4000, 16'd0);
    wait_done("zero", 10);
    check("zero_ar_valid_cycles", 32'(arvalid_cyc), 0);
    check("zero_wen", 32'(wen_cnt), 0);

    // r_last protocol error, sticky through done, cleared by next start
    clear_stats();
    err_mode = 1'b1;
    exp_ar_q.push_back(32'h0000_5000);
    exp_done_q.push_back(1'b1);
    start_job(32'h0000_5000, 16'd1);
    wait_done("err", 100);
    @(negedge clk); #1;
    check("err_sticky_idle", 32'(bus.err_last), 1);
    err_mode = 1'b0;
    exp_ar_q.push_back(32'h0000_6000);
    exp_done_q.push_back(1'b0);
    start_job(32'h0000_6000, 16'd1);
    check("err_cleared_by_start", 32'(bus.err_last), 0);
    wait_done("err_clear", 100);

    // reset while draining
    bus.out_ready = 1'b0;
    exp_ar_q.push_back(32'h0000_7000);
    start_job(32'h0000_7000, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (state_o == ST_DRAIN && bus.level == 4'd4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("rst_drain_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_stats();
    exp_ar_q.push_back(32'h0000_8000);
    exp_done_q.push_back(1'b0);
    start_job(32'h0000_8000, 16'd1);
    wait_done("after_rst", 100);
    check("after_rst_wen", 32'(wen_cnt), 4);
    check("after_rst_ren", 32'(ren_cnt), 4);

    repeat (2) @(negedge clk);
    check("exp_ar_drained", 32'(exp_ar_q.size()), 0);
    check("exp_done_drained", 32'(exp_done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
